// File: rtl/serial_word_rx.sv
// -----------------------------------------------------------------------------
// serial_word_rx
//
// Receive end of a shift-mode register's serial output path. Qualified serial
// bits (ser_valid high) are shifted into an internal register; every WIDTH
// bits the assembled word is offered to a one-entry output buffer that the
// consumer drains with word_ack. A word that completes while the buffer still
// holds an unconsumed word is dropped and the sticky overrun flag is set.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: first received bit lands in word_out[WIDTH-1]
//              0: first received bit lands in word_out[0]
//
// Ports
//   clock       in   system clock, all state updates on the rising edge
//   reset       in   asynchronous, active-high reset
//   ser_in      in   serial data bit
//   ser_valid   in   ser_in is sampled on this rising edge when high
//   clear       in   synchronous flush of all state (beats ser_valid/word_ack)
//   word_ack    in   consumer has taken word_out
//   word_out    out  last completed word (registered)
//   word_valid  out  word_out holds an unconsumed word (buffer FSM is FULL)
//   overrun     out  sticky: a completed word was dropped
//   bit_count   out  bits collected toward the current word
//   busy        out  partial word in progress (bit_count != 0)
//
// Handshake: word_valid stays high, and word_out stable, until the consumer
// samples word_ack high on a rising edge. An ack while word_valid is low is
// ignored. An ack on the same edge as a completion frees the slot for the new
// word, so that word is accepted rather than counted as an overrun.
// -----------------------------------------------------------------------------
module serial_word_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ser_in,
    input  logic                     ser_valid,
    input  logic                     clear,
    input  logic                     word_ack,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state;
    buf_state_t       state_next;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;
    logic             complete;
    logic             load_word;
    logic             set_overrun;

    // -------------------------------------------------------------------------
    // Collection datapath
    // -------------------------------------------------------------------------

    // sh_next is the shift register with the current bit already included; on
    // the completion edge it is the finished word, so the buffer can load it on
    // the same edge that samples the last bit.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sh_next = {sh[WIDTH-2:0], ser_in};
        end else begin : g_lsb_first
            assign sh_next = {ser_in, sh[WIDTH-1:1]};
        end
    endgenerate

    assign complete = ser_valid && (cnt == LAST_BIT);

    // Collection never stalls: bits keep arriving regardless of buffer state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sh  <= '0;
            cnt <= '0;
        end else if (ser_valid) begin
            sh <= sh_next;
            if (complete) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output buffer FSM
    // -------------------------------------------------------------------------

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else if (clear) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_word   = 1'b0;
        set_overrun = 1'b0;
        case (state)
            EMPTY: begin
                // An ack with nothing buffered has no effect.
                if (complete) begin
                    state_next = FULL;
                    load_word  = 1'b1;
                end
            end
            FULL: begin
                if (complete && word_ack) begin
                    // Consumer frees the slot on the same edge: replace.
                    state_next = FULL;
                    load_word  = 1'b1;
                end else if (complete) begin
                    // Slot still occupied: keep the old word, drop the new one.
                    state_next  = FULL;
                    set_overrun = 1'b1;
                end else if (word_ack) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // word_out keeps its value after an ack; only a load replaces it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_out <= '0;
            overrun  <= 1'b0;
        end else if (clear) begin
            word_out <= '0;
            overrun  <= 1'b0;
        end else begin
            if (load_word) begin
                word_out <= sh_next;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status outputs (the buffer state is visible directly as word_valid)
    // -------------------------------------------------------------------------

    assign word_valid = (state == FULL);
    assign bit_count  = cnt;
    assign busy       = (cnt != '0);

endmodule
